// File: rtl/fifo_rd_ptr_empty_if.sv
// Read-side pointer bundle between the FIFO consumer logic and the read-pointer/empty block.
interface fifo_rd_ptr_empty_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  R_INC;
  logic [ADDR_WIDTH:0]   WR_PTR_SYNC;
  logic [ADDR_WIDTH-1:0] R_ADDR;
  logic [ADDR_WIDTH:0]   RD_PTR_GREY;
  logic                  RD_EN;
  logic                  EMPTY;
  logic [ADDR_WIDTH:0]   RD_LEVEL;
  logic                  UNDERFLOW;

  modport master (
    output R_INC, WR_PTR_SYNC,
    input  R_ADDR, RD_PTR_GREY, RD_EN, EMPTY, RD_LEVEL, UNDERFLOW
  );

  modport slave (
    input  R_INC, WR_PTR_SYNC,
    output R_ADDR, RD_PTR_GREY, RD_EN, EMPTY, RD_LEVEL, UNDERFLOW
  );
endinterface

// File: rtl/fifo_rd_ptr_empty.sv
// Async-FIFO read pointer: binary/Gray pointer pair, registered empty flag,
// read-side fill level and a sticky underflow flag.
module fifo_rd_ptr_empty #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  fifo_rd_ptr_empty_if.slave   rd
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] wbin;
  logic          empty_q, empty_d;
  logic          uf_q, uf_d;
  logic          rd_en;

  // Gray-to-binary per bit as the XOR of all higher-or-equal Gray bits,
  // which avoids a self-referencing ripple chain on wbin.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_wbin
      assign wbin[gi] = ^rd.WR_PTR_SYNC[PW-1:gi];
    end
  endgenerate

  // Gated with the registered flag so the accept never depends on this cycle's compare.
  assign rd_en = rd.R_INC & ~empty_q & ~RST;

  always_comb begin
    rbin_d  = rbin_q + PW'(rd_en);
    rgray_d = rbin_d ^ (rbin_d >> 1);
    empty_d = (rgray_d == rd.WR_PTR_SYNC);
    level_d = wbin - rbin_d;
    uf_d    = uf_q | (rd.R_INC & empty_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      level_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      level_q <= level_d;
      uf_q    <= uf_d;
    end
  end

  assign rd.R_ADDR      = RST ? '0 : rbin_q[ADDR_WIDTH-1:0];
  assign rd.RD_PTR_GREY = rgray_q;
  assign rd.RD_EN       = rd_en;
  assign rd.EMPTY       = empty_q;
  assign rd.RD_LEVEL    = level_q;
  assign rd.UNDERFLOW   = uf_q;
endmodule
